muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, results written to architectural HI/LO behind a start/busy/done handshake.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             isDiv_q;
    logic             divZero_q;
    logic             signA_q;
    logic             signB_q;
    logic [WIDTH-1:0] bMag_q;
    logic [WIDTH-1:0] accHi_q;
    logic [WIDTH-1:0] accLo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             opSigned;
    logic             inSignA;
    logic             inSignB;
    logic             inDivZero;
    logic [WIDTH-1:0] inMagA;
    logic [WIDTH-1:0] inMagB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divTrial;
    logic             divFits;
    logic [WIDTH-1:0] accHi_d;
    logic [WIDTH-1:0] accLo_d;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] fixHi_d;
    logic [WIDTH-1:0] fixLo_d;

    always_comb begin
        opSigned  = ~op[0];
        inSignA   = opSigned & a[WIDTH-1];
        inSignB   = opSigned & b[WIDTH-1];
        inMagA    = inSignA ? -a : a;
        inMagB    = inSignB ? -b : b;
        inDivZero = op[1] & (b == '0);
    end

    // accHi/accLo hold the running product (multiply) or remainder/quotient (divide);
    // the dividend or multiplier magnitude starts in accLo and is shifted out one bit per step.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, bMag_q} : {(WIDTH+1){1'b0}});
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divFits  = (divShift >= {1'b0, bMag_q});
        divTrial = divShift - {1'b0, bMag_q};
        if (isDiv_q) begin
            accHi_d = WIDTH'(divFits ? divTrial : divShift);
            accLo_d = {accLo_q[WIDTH-2:0], divFits};
        end else begin
            accHi_d = mulSum[WIDTH:1];
            accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        product = {accHi_q, accLo_q};
        fixHi_d = accHi_q;
        fixLo_d = accLo_q;
        if (divZero_q) begin
            fixHi_d = accLo_q;
            fixLo_d = '1;
        end else if (isDiv_q) begin
            fixLo_d = (signA_q ^ signB_q) ? -accLo_q : accLo_q;
            fixHi_d = signA_q ? -accHi_q : accHi_q;
        end else begin
            if (signA_q ^ signB_q) begin
                product = -product;
            end
            fixHi_d = product[2*WIDTH-1:WIDTH];
            fixLo_d = product[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            signA_q   <= 1'b0;
            signB_q   <= 1'b0;
            bMag_q    <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A zero divisor keeps the raw dividend in accLo so FIX can return it untouched.
                    if (start) begin
                        isDiv_q   <= op[1];
                        divZero_q <= inDivZero;
                        signA_q   <= inSignA;
                        signB_q   <= inSignB;
                        bMag_q    <= inMagB;
                        accHi_q   <= '0;
                        accLo_q   <= inDivZero ? a : inMagA;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= inDivZero ? FIX : RUN;
                    end
                end
                RUN: begin
                    accHi_q <= accHi_d;
                    accLo_q <= accLo_d;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        cnt_q   <= '0;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                FIX: begin
                    hi_q    <= fixHi_d;
                    lo_q    <= fixLo_d;
                    dbz_q   <= divZero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a transaction-level reference (64-bit arithmetic plus a latency
// countdown) is compared against the DUT every cycle, alongside hand-computed results.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } result_t;

    logic    mBusy    = 1'b0;
    logic    mDone    = 1'b0;
    result_t mRes     = '0;
    result_t mPending = '0;
    int      mLeft    = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expHi,
                               input logic [31:0] expLo, input logic expDbz);
        checkVal({name, "_hi"}, 64'(hi), 64'(expHi));
        checkVal({name, "_lo"}, 64'(lo), 64'(expLo));
        checkVal({name, "_dbz"}, 64'(div_by_zero), 64'(expDbz));
    endtask

    // Architectural result of one operation using plain 64-bit arithmetic.
    function automatic result_t refOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        result_t     r;
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] m;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        r.dbz = 1'b0;
        p     = '0;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) begin
                    p = {x, 32'hFFFFFFFF};
                    r.dbz = 1'b1;
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    p = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) begin
                    p = {x, 32'hFFFFFFFF};
                    r.dbz = 1'b1;
                end else begin
                    q = {32'b0, x} / {32'b0, y};
                    m = {32'b0, x} % {32'b0, y};
                    p = {m[31:0], q[31:0]};
                end
            end
        endcase
        r.hi = p[63:32];
        r.lo = p[31:0];
        return r;
    endfunction

    // Reference timing: an accepted request completes WIDTH+1 edges later (1 for divide-by-zero).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0;
            mDone = 1'b0;
            mRes  = '0;
            mLeft = 0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                mLeft--;
                if (mLeft == 0) begin
                    mBusy = 1'b0;
                    mDone = 1'b1;
                    mRes  = mPending;
                end
            end else if (start) begin
                mBusy    = 1'b1;
                mPending = refOp(op, a, b);
                mLeft    = (op[1] && b == 0) ? 1 : WIDTH + 1;
            end
        end
    end

    always @(negedge clk) begin
        checkVal("busy", 64'(busy), 64'(mBusy));
        checkVal("done", 64'(done), 64'(mDone));
        checkVal("hilo", {hi, lo}, {mRes.hi, mRes.lo});
        checkVal("dbzFlag", 64'(div_by_zero), 64'(mRes.dbz));
    end

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        lat   = 0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                start = 1'b0;
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            lat++;
        end while (!done && lat < 200);
        if (!done) checkVal("doneTimeout", 64'(done), 64'd1);
    endtask

    initial begin
        int      lat;
        result_t r;

        #1 rst_n = 1'b0;
        r = refOp(2'b10, 32'hFFFFFFF9, 32'd2);
        checkVal("refDiv", {r.hi, r.lo}, 64'hFFFFFFFF_FFFFFFFD);
        r = refOp(2'b00, 32'hFFFFFFFD, 32'd5);
        checkVal("refMult", {r.hi, r.lo}, 64'hFFFFFFFF_FFFFFFF1);
        r = refOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
        checkVal("refDivOvf", {r.hi, r.lo}, 64'h00000000_80000000);

        @(negedge clk);
        checkVal("resetBusy", 64'(busy), 64'd0);
        checkVal("resetDone", 64'(done), 64'd0);
        checkOutput("reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(2'b01, 32'hFFFFFFFF, 32'd2, lat);
        checkVal("latMultu", 64'(lat), 64'd34);
        checkOutput("multu", 32'h00000001, 32'hFFFFFFFE, 1'b0);
        @(negedge clk);

        applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, lat);
        checkOutput("mult", 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        @(negedge clk);
        checkVal("doneWidth", 64'(done), 64'd0);

        applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, lat);
        checkOutput("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        applyStimulus(2'b11, 32'd100, 32'd23, lat);
        checkOutput("divu", 32'd8, 32'd4, 1'b0);
        applyStimulus(2'b11, 32'd100, 32'd0, lat);
        checkVal("latDbz", 64'(lat), 64'd2);
        checkOutput("dbz", 32'd100, 32'hFFFFFFFF, 1'b1);
        applyStimulus(2'b01, 32'd3, 32'd4, lat);
        checkOutput("afterDbz", 32'd0, 32'd12, 1'b0);
        applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
        checkOutput("divOvf", 32'd0, 32'h80000000, 1'b0);
        @(negedge clk);

        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7; lat = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            lat++;
            start = (i == 10);
            if (i == 10) begin
                op = 2'b01; a = 32'd7; b = 32'd7;
            end
        end
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkVal("latBusyIgnore", 64'(lat), 64'd34);
        checkOutput("busyIgnore", 32'd6, 32'd142, 1'b0);
        @(negedge clk);
        checkVal("notQueued", 64'(busy), 64'd0);

        start = 1'b1; op = 2'b00; a = 32'h00012345; b = 32'h00000777;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkVal("rstBusy", 64'(busy), 64'd0);
        checkVal("rstDone", 64'(done), 64'd0);
        checkOutput("rstMid", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(2'b00, 32'd6, 32'd7, lat);
        checkVal("latAfterRst", 64'(lat), 64'd34);
        checkOutput("afterRst", 32'd0, 32'd42, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = y >> $urandom_range(0, 31);
                2: x = 32'h80000000;
                3: y = 32'hFFFFFFFF;
                default: ;
            endcase
            applyStimulus(o, x, y, lat);
            checkVal("randLat", 64'(lat), (o[1] && y == 0) ? 64'd2 : 64'd34);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
